// File: rtl/prog_counter_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM states,
// program start addresses and the start-address lookup.
package prog_counter_pkg;

  localparam int DEFAULT_PC_W  = 12;
  localparam int DEFAULT_CYC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  // These must track the entry points in the decoder's jump target table.
  localparam logic [DEFAULT_PC_W-1:0] kProgStart1 = 12'h000;
  localparam logic [DEFAULT_PC_W-1:0] kProgStart2 = 12'h003;
  localparam logic [DEFAULT_PC_W-1:0] kProgStart3 = 12'h040;

  function automatic logic [DEFAULT_PC_W-1:0] prog_start(input logic [1:0] sel);
    logic [DEFAULT_PC_W-1:0] addr;
    addr = '0;
    case (sel)
      2'd1:    addr = kProgStart1;
      2'd2:    addr = kProgStart2;
      2'd3:    addr = kProgStart3;
      default: addr = '0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/prog_counter_cycle_counter.sv
// Saturating up-counter with synchronous reset, synchronous clear and count enable.
module cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic at_max;
  assign at_max = &count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Fetch-stage program counter: start/run/halt sequencing, jump redirect
// from the control decoder and a saturating RUN-cycle counter.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int CYC_W = DEFAULT_CYC_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             jump_en,
  input  logic [15:0]      Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CYC_W-1:0] CycleCt,
  output state_t           state_dbg
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              cyc_clr;
  logic              cyc_en;
  logic              unused_target;

  // Target is wider than the PC; the high bits are intentionally discarded.
  assign unused_target = ^Target;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
    end else begin
      state   <= state_nxt;
      ProgCtr <= pc_nxt;
    end
  end

  // Start overrides every state, so Halt/jump_en only matter in RUN without Start.
  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    cyc_clr   = 1'b0;
    cyc_en    = 1'b0;
    if (Start) begin
      state_nxt = LOAD;
      pc_nxt    = PC_W'(prog_start(ProgSel));
      cyc_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: state_nxt = RUN;
        RUN: begin
          cyc_en = 1'b1;
          if (Halt) begin
            state_nxt = HALTED;
          end else if (jump_en) begin
            pc_nxt = PC_W'(Target);
          end else begin
            pc_nxt = ProgCtr + PC_W'(1);
          end
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Running   = (state == RUN);
  assign Done      = (state == HALTED);
  assign state_dbg = state;

  cycle_counter #(
    .W(CYC_W)
  ) u_cycle_counter (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (cyc_clr),
    .en   (cyc_en),
    .count(CycleCt)
  );

endmodule
